// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffers payload bytes, then sends SYNC, LEN, payload and an
// additive checksum to uart_tx one byte at a time over its DV/Done handshake.
module uart_frame_tx #(
   parameter int unsigned MAX_LEN   = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                           i_Clock,
   input  logic                           i_Reset,
   input  logic                           i_Wr_En,
   input  logic [7:0]                     i_Wr_Byte,
   input  logic                           i_Start,
   input  logic                           i_Tx_Done,
   output logic                           o_Tx_DV,
   output logic [7:0]                     o_Tx_Byte,
   output logic                           o_Busy,
   output logic                           o_Done,
   output logic [$clog2(MAX_LEN+1)-1:0]   o_Count,
   output logic                           o_Overflow
);

   localparam int unsigned CW    = $clog2(MAX_LEN + 1);
   // Buffer address width; at least one bit so MAX_LEN = 1 still has an index
   localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWaitDone,
      StGap
   } state_e;

   state_e     state_q;
   logic [7:0] buf_q [DEPTH];
   logic [7:0] len_q;
   logic [7:0] chk_q;
   // Frame byte index: 0 = SYNC, 1 = LEN, 2..LEN+1 = payload, LEN+2 = CHK
   logic [8:0] idx_q;

   logic       start_ok;
   logic       wr_ok;
   logic       is_chk;
   logic       in_sum;
   logic [8:0] pay_idx;
   logic [7:0] cur_byte;

   // Accept decisions and the byte selected by the current frame index
   always_comb begin
      start_ok = (state_q == StIdle) && i_Start;
      wr_ok    = i_Wr_En && (state_q == StIdle) && !i_Start && (o_Count < CW'(MAX_LEN));
      pay_idx  = idx_q - 9'd2;
      is_chk   = (idx_q == ({1'b0, len_q} + 9'd2));
      in_sum   = (idx_q != 9'd0) && !is_chk;
      if (idx_q == 9'd0) begin
         cur_byte = SYNC_BYTE;
      end else if (idx_q == 9'd1) begin
         cur_byte = len_q;
      end else if (is_chk) begin
         cur_byte = chk_q;
      end else begin
         cur_byte = buf_q[pay_idx[AW-1:0]];
      end
   end

   // Payload storage; contents are only meaningful below o_Count, so no reset
   always_ff @(posedge i_Clock) begin
      if (wr_ok) begin
         buf_q[o_Count[AW-1:0]] <= i_Wr_Byte;
      end
   end

   // Frame FSM with registered handshake and status outputs
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= StIdle;
         len_q      <= 8'h00;
         chk_q      <= 8'h00;
         idx_q      <= 9'd0;
         o_Tx_DV    <= 1'b0;
         o_Tx_Byte  <= 8'h00;
         o_Busy     <= 1'b0;
         o_Done     <= 1'b0;
         o_Count    <= '0;
         o_Overflow <= 1'b0;
      end else begin
         o_Tx_DV <= 1'b0;
         o_Done  <= 1'b0;

         if (wr_ok) begin
            o_Count <= o_Count + CW'(1);
         end

         // A dropped write in the same cycle as a start still leaves the flag set
         if (i_Wr_En && !wr_ok) begin
            o_Overflow <= 1'b1;
         end else if (start_ok) begin
            o_Overflow <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (i_Start) begin
                  len_q     <= 8'(o_Count);
                  chk_q     <= 8'h00;
                  idx_q     <= 9'd0;
                  o_Tx_DV   <= 1'b1;
                  o_Tx_Byte <= SYNC_BYTE;
                  o_Busy    <= 1'b1;
                  state_q   <= StSend;
               end
            end
            // DV is high during this state; just move on to wait for the stop bit
            StSend: begin
               state_q <= StWaitDone;
            end
            StWaitDone: begin
               if (i_Tx_Done) begin
                  if (is_chk) begin
                     o_Done  <= 1'b1;
                     o_Busy  <= 1'b0;
                     o_Count <= '0;
                     state_q <= StIdle;
                  end else begin
                     if (in_sum) begin
                        chk_q <= chk_q + cur_byte;
                     end
                     idx_q   <= idx_q + 9'd1;
                     state_q <= StGap;
                  end
               end
            end
            // Idle cycle so uart_tx is back in its idle state before the next DV
            StGap: begin
               o_Tx_DV   <= 1'b1;
               o_Tx_Byte <= cur_byte;
               state_q   <= StSend;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: scoreboard of expected frame bytes checked by a DV
// monitor, a small uart_tx stand-in that answers each DV with a Done pulse.
module tb_uart_frame_tx;

   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned CW      = $clog2(MAX_LEN + 1);

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [7:0]    wr_byte;
   logic          start;
   logic          tx_done;
   logic          tx_dv;
   logic [7:0]    tx_byte;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;
   logic          ovf;

   int            n_checks = 0;
   int            n_pass   = 0;
   int            dv_seen  = 0;
   logic [7:0]    exp_q [$];
   bit            stale    = 1'b0;

   uart_frame_tx #(
      .MAX_LEN   (MAX_LEN),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .i_Clock    (clk),
      .i_Reset    (rst),
      .i_Wr_En    (wr_en),
      .i_Wr_Byte  (wr_byte),
      .i_Start    (start),
      .i_Tx_Done  (tx_done),
      .o_Tx_DV    (tx_dv),
      .o_Tx_Byte  (tx_byte),
      .o_Busy     (busy),
      .o_Done     (done),
      .o_Count    (count),
      .o_Overflow (ovf)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_byte = b;
      cyc();
      wr_en   = 1'b0;
   endtask

   // Queue the full expected frame for the given payload, then pulse start
   task automatic send_frame(input logic [7:0] pl [$]);
      logic [7:0] chk;
      chk = 8'(pl.size());
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(pl.size()));
      foreach (pl[i]) begin
         exp_q.push_back(pl[i]);
         chk = chk + pl[i];
      end
      exp_q.push_back(chk);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         cyc();
         if (done) begin
            seen = 1'b1;
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
            check({name, "_count_at_done"}, 32'(count), 32'd0);
         end
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      cyc();
      check({name, "_done_single"}, 32'(done), 32'd0);
   endtask

   // Scoreboard monitor: every DV pops and compares one expected byte
   initial begin
      bit prev_dv = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_dv) begin
            dv_seen++;
            if (prev_dv) check("dv_width", 32'(prev_dv), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_dv", 32'(tx_byte), 32'hFFFF_FFFF);
            end else begin
               check("frame_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
         end
         prev_dv = tx_dv;
      end
   end

   // uart_tx stand-in: Done pulse a few cycles after each DV, byte held meanwhile
   initial begin
      int         cnt = 0;
      logic [7:0] held = 8'h00;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               tx_done = 1'b1;
               if (!stale) check("byte_stable", 32'(tx_byte), 32'(held));
            end
         end else if (tx_dv) begin
            cnt   = 6;
            held  = tx_byte;
            stale = 1'b0;
         end
      end
   end

   initial begin
      logic [7:0] pl [$];
      int base;

      rst = 1'b1; wr_en = 1'b0; wr_byte = 8'h00; start = 1'b0;
      repeat (3) cyc();
      check("rst_dv",    32'(tx_dv),   32'd0);
      check("rst_byte",  32'(tx_byte), 32'h00);
      check("rst_busy",  32'(busy),    32'd0);
      check("rst_done",  32'(done),    32'd0);
      check("rst_count", 32'(count),   32'd0);
      check("rst_ovf",   32'(ovf),     32'd0);
      rst = 1'b0;
      cyc();

      // Three-byte frame: A5 03 3F AB 01 EE
      pl = '{8'h3F, 8'hAB, 8'h01};
      foreach (pl[i]) write_byte(pl[i]);
      check("t1_count", 32'(count), 32'd3);
      send_frame(pl);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1");
      check("t1_ovf", 32'(ovf), 32'd0);

      // Empty frame: A5 00 00
      pl = {};
      send_frame(pl);
      wait_done("t2");
      check("t2_ovf", 32'(ovf), 32'd0);

      // Checksum wrap: A5 02 FF FF 00
      pl = '{8'hFF, 8'hFF};
      foreach (pl[i]) write_byte(pl[i]);
      send_frame(pl);
      wait_done("t3");

      // Overfill: 17 writes keep 16, flag overflow, CHK = 0x88
      pl = {};
      for (int i = 0; i < 17; i++) begin
         write_byte(8'(i));
         if (i < 16) pl.push_back(8'(i));
      end
      check("t4_count", 32'(count), 32'd16);
      check("t4_ovf", 32'(ovf), 32'd1);
      send_frame(pl);
      check("t4_ovf_cleared", 32'(ovf), 32'd0);
      wait_done("t4");

      // Start and write while busy: ignored start, dropped write
      pl = '{8'h10, 8'h20, 8'h30};
      foreach (pl[i]) write_byte(pl[i]);
      send_frame(pl);
      repeat (3) cyc();
      start = 1'b1; wr_en = 1'b1; wr_byte = 8'h99;
      cyc();
      start = 1'b0; wr_en = 1'b0;
      check("t5_ovf", 32'(ovf), 32'd1);
      check("t5_count", 32'(count), 32'd3);
      wait_done("t5");
      repeat (40) cyc();
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset during payload of a 4-byte frame
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      foreach (pl[i]) write_byte(pl[i]);
      base = dv_seen;
      send_frame(pl);
      for (int i = 0; i < 500 && dv_seen < base + 3; i++) cyc();
      check("t6_reached_payload", 32'(dv_seen >= base + 3), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      stale = 1'b1;
      cyc();
      check("t6_rst_dv",    32'(tx_dv),   32'd0);
      check("t6_rst_byte",  32'(tx_byte), 32'h00);
      check("t6_rst_busy",  32'(busy),    32'd0);
      check("t6_rst_done",  32'(done),    32'd0);
      check("t6_rst_count", 32'(count),   32'd0);
      check("t6_rst_ovf",   32'(ovf),     32'd0);
      rst = 1'b0;
      repeat (40) cyc();
      pl = '{8'h55};
      write_byte(8'h55);
      check("t6_count", 32'(count), 32'd1);
      send_frame(pl);
      wait_done("t6");
      repeat (10) cyc();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
